// File: rtl/uart_tx_engine_if.sv
// Bridge-to-transmitter signal bundle for uart_tx_engine: control/data in, serial line and flags out.
interface uart_tx_engine_if;
  logic       tx_enable;
  logic       send;
  logic [7:0] DATA_TX;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       tx_out;
  logic       tx_active_flag;
  logic       tx_done_flag;

  modport master (
    output tx_enable, send, DATA_TX, parity_type, baud_rate,
    input  tx_out, tx_active_flag, tx_done_flag
  );

  modport slave (
    input  tx_enable, send, DATA_TX, parity_type, baud_rate,
    output tx_out, tx_active_flag, tx_done_flag
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional odd/even parity, stop bit(s).
// Build option: define UART_TX_STOP2_EN for two stop bits (default build sends one).
module uart_tx_engine #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  uart_tx_engine_if.slave bus
);

  localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
  localparam int unsigned DIV_19200  = CLK_FREQ / 19200;
  localparam int unsigned DIV_38400  = CLK_FREQ / 38400;
  localparam int unsigned DIV_115200 = CLK_FREQ / 115200;

`ifdef UART_TX_STOP2_EN
  localparam int unsigned STOP_BITS = 2;
`else
  localparam int unsigned STOP_BITS = 1;
`endif

  localparam int unsigned CNT_W = $clog2(STOP_BITS * DIV_9600 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic int unsigned div_of(input logic [1:0] code);
    int unsigned d;
    case (code)
      2'b00:   d = DIV_9600;
      2'b01:   d = DIV_19200;
      2'b10:   d = DIV_38400;
      default: d = DIV_115200;
    endcase
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] bit_reload(input logic [1:0] code);
    return CNT_W'(div_of(code) - 1);
  endfunction

  function automatic logic [CNT_W-1:0] stop_reload(input logic [1:0] code);
    return CNT_W'(STOP_BITS * div_of(code) - 1);
  endfunction

  function automatic logic par_en(input logic [1:0] ptype);
    return (ptype == 2'b01) || (ptype == 2'b10);
  endfunction

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       idx_q, idx_n;
  logic [7:0]       data_q, data_n;
  logic [1:0]       ptype_q, ptype_n;
  logic [1:0]       baud_q, baud_n;
  logic             send_d;
  logic             tx_out_q, tx_out_n;
  logic             done_q, done_n;
  logic             accept, frame_end;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ptype_q  <= '0;
      baud_q   <= '0;
      send_d   <= 1'b0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      data_q   <= data_n;
      ptype_q  <= ptype_n;
      baud_q   <= baud_n;
      send_d   <= bus.send;
      tx_out_q <= tx_out_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    data_n    = data_q;
    ptype_n   = ptype_q;
    baud_n    = baud_q;
    accept    = 1'b0;
    frame_end = 1'b0;
    if (state_q != IDLE && !bus.tx_enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tx_enable && bus.send && !send_d) begin
            accept  = 1'b1;
            state_n = START;
            data_n  = bus.DATA_TX;
            ptype_n = bus.parity_type;
            baud_n  = bus.baud_rate;
            cnt_n   = bit_reload(bus.baud_rate);
            idx_n   = '0;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            state_n = DATA;
            cnt_n   = bit_reload(baud_q);
            idx_n   = '0;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            if (idx_q == 3'd7) begin
              idx_n = '0;
              if (par_en(ptype_q)) begin
                state_n = PARITY;
                cnt_n   = bit_reload(baud_q);
              end else begin
                state_n = STOP;
                cnt_n   = stop_reload(baud_q);
              end
            end else begin
              idx_n = idx_q + 3'd1;
              cnt_n = bit_reload(baud_q);
            end
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        PARITY: begin
          if (cnt_q == '0) begin
            state_n = STOP;
            cnt_n   = stop_reload(baud_q);
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            state_n   = IDLE;
            frame_end = 1'b1;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Line level is derived from next-state values so the registered tx_out lines up with the state it belongs to.
  always_comb begin
    case (state_n)
      START:   tx_out_n = 1'b0;
      DATA:    tx_out_n = data_n[idx_n];
      PARITY:  tx_out_n = (ptype_n == 2'b10) ? ^data_n : ~^data_n;
      default: tx_out_n = 1'b1;
    endcase
    done_n = done_q;
    if (accept) begin
      done_n = 1'b0;
    end else if (frame_end) begin
      done_n = 1'b1;
    end
    bus.tx_out         = tx_out_q;
    bus.tx_active_flag = (state_q != IDLE);
    bus.tx_done_flag   = done_q;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: vector table, directed corner sequences and random frames against a frame-level model.
module tb_uart_tx_engine;
  localparam int unsigned CLK_FREQ = 1152000;
`ifdef UART_TX_STOP2_EN
  localparam int unsigned NSTOP = 2;
`else
  localparam int unsigned NSTOP = 1;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fails = 0;

  uart_tx_engine_if bus ();

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  ptype;
    logic [1:0]  baud;
    int unsigned div;
    int unsigned len_1stop;
    logic        has_par;
    logic        par_bit;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned model_div(input logic [1:0] baud);
    int unsigned rate;
    case (baud)
      2'b00:   rate = 9600;
      2'b01:   rate = 19200;
      2'b10:   rate = 38400;
      default: rate = 115200;
    endcase
    return CLK_FREQ / rate;
  endfunction

  task automatic launch(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br);
    @(negedge PCLK);
    bus.send = 1'b0;
    @(negedge PCLK);
    bus.DATA_TX     = d;
    bus.parity_type = pt;
    bus.baud_rate   = br;
    bus.send        = 1'b1;
  endtask

  // mode 0: drop send; 1: change data/baud mid-frame; 2: hold send; 3: pulse send mid-frame
  task automatic expect_frame(input string name, input logic [7:0] d, input logic [1:0] pt,
                              input logic [1:0] br, input int unsigned mode,
                              output int unsigned active_cnt, output logic par_sample);
    bit          q[$];
    int unsigned div, len, mism, first;
    logic        ex, fo, fa, fd, fe;
    div = model_div(br);
    q.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++) q.push_back(d[i]);
    if (pt == 2'b01) q.push_back(~^d);
    else if (pt == 2'b10) q.push_back(^d);
    for (int unsigned i = 0; i < NSTOP; i++) q.push_back(1'b1);
    len = q.size() * div;
    mism = 0; first = 0; active_cnt = 0; par_sample = 1'b1;
    fo = 1'b0; fa = 1'b0; fd = 1'b0; fe = 1'b0;
    for (int unsigned k = 0; k < len; k++) begin
      @(negedge PCLK);
      ex = q[k / div];
      if (bus.tx_active_flag === 1'b1) active_cnt++;
      if (k == 9 * div + div / 2) par_sample = bus.tx_out;
      if (bus.tx_out !== ex || bus.tx_active_flag !== 1'b1 || bus.tx_done_flag !== 1'b0) begin
        if (mism == 0) begin
          first = k; fo = bus.tx_out; fa = bus.tx_active_flag; fd = bus.tx_done_flag; fe = ex;
        end
        mism++;
      end
      if ((mode == 0 || mode == 1) && k == 0) bus.send = 1'b0;
      if (mode == 1 && k == 25) begin
        bus.DATA_TX   = 8'hFF;
        bus.baud_rate = 2'b00;
      end
      if (mode == 3 && k == 20) bus.send = 1'b0;
      if (mode == 3 && k == 25) bus.send = 1'b1;
    end
    n_checks++;
    if (mism != 0) begin
      n_fails++;
      $display("FAIL %s_wave: %0d bad cycles, first at cycle %0d: tx_out=%b active=%b done=%b, required tx_out=%b active=1 done=0",
               name, mism, first, fo, fa, fd, fe);
    end
    @(negedge PCLK);
    if (bus.tx_active_flag === 1'b1) active_cnt++;
    check({name, "_end"}, 32'({bus.tx_out, bus.tx_active_flag, bus.tx_done_flag}), 32'h5);
  endtask

  task automatic idle_check(input string name, input int unsigned n);
    int unsigned busy = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge PCLK);
      if (bus.tx_active_flag !== 1'b0 || bus.tx_out !== 1'b1) busy++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[6];
    int unsigned acnt;
    logic        psmp;
    logic [7:0]  rd;
    logic [1:0]  rp, rb;
    int unsigned waited;

    bus.tx_enable = 1'b0; bus.send = 1'b0; bus.DATA_TX = '0;
    bus.parity_type = '0; bus.baud_rate = '0;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_outputs", 32'({bus.tx_out, bus.tx_active_flag, bus.tx_done_flag}), 32'h4);
    PRESETn = 1'b1;
    bus.tx_enable = 1'b1;
    @(negedge PCLK);
    check("idle_after_reset", 32'({bus.tx_out, bus.tx_active_flag, bus.tx_done_flag}), 32'h4);

    vt[0] = '{8'h55, 2'b00, 2'b11, 10, 100, 1'b0, 1'b0};
    vt[1] = '{8'h07, 2'b10, 2'b11, 10, 110, 1'b1, 1'b1};
    vt[2] = '{8'h07, 2'b01, 2'b11, 10, 110, 1'b1, 1'b0};
    vt[3] = '{8'hA3, 2'b11, 2'b10, 30, 300, 1'b0, 1'b0};
    vt[4] = '{8'h00, 2'b01, 2'b11, 10, 110, 1'b1, 1'b1};
    vt[5] = '{8'hC4, 2'b10, 2'b01, 60, 660, 1'b1, 1'b1};
    for (int unsigned i = 0; i < 6; i++) begin
      launch(vt[i].data, vt[i].ptype, vt[i].baud);
      expect_frame($sformatf("vec%0d", i), vt[i].data, vt[i].ptype, vt[i].baud, 0, acnt, psmp);
      check($sformatf("vec%0d_len", i), acnt, vt[i].len_1stop + (NSTOP - 1) * vt[i].div);
      if (vt[i].has_par) check($sformatf("vec%0d_parity", i), 32'(psmp), 32'(vt[i].par_bit));
    end

    launch(8'h55, 2'b00, 2'b11);
    expect_frame("midframe_change", 8'h55, 2'b00, 2'b11, 1, acnt, psmp);

    launch(8'h3C, 2'b10, 2'b11);
    expect_frame("send_held", 8'h3C, 2'b10, 2'b11, 2, acnt, psmp);
    idle_check("held_send_no_restart", 30);
    launch(8'h96, 2'b01, 2'b11);
    expect_frame("send_pulsed", 8'h96, 2'b01, 2'b11, 3, acnt, psmp);
    idle_check("pulse_ignored", 30);
    launch(8'h81, 2'b00, 2'b11);
    expect_frame("relaunch", 8'h81, 2'b00, 2'b11, 0, acnt, psmp);

    launch(8'h00, 2'b00, 2'b11);
    repeat (44) @(negedge PCLK);
    check("pre_abort_data3", 32'({bus.tx_out, bus.tx_active_flag}), 32'h1);
    bus.tx_enable = 1'b0;
    bus.send = 1'b0;
    @(negedge PCLK);
    check("abort_next_cycle", 32'({bus.tx_out, bus.tx_active_flag, bus.tx_done_flag}), 32'h4);
    repeat (20) @(negedge PCLK);
    check("abort_done_stays_0", 32'({bus.tx_out, bus.tx_active_flag, bus.tx_done_flag}), 32'h4);

    @(negedge PCLK);
    bus.DATA_TX = 8'h5A; bus.parity_type = 2'b10; bus.baud_rate = 2'b11;
    bus.tx_enable = 1'b1;
    bus.send = 1'b1;
    expect_frame("enable_with_send", 8'h5A, 2'b10, 2'b11, 0, acnt, psmp);

    launch(8'h07, 2'b10, 2'b11);
    repeat (95) @(negedge PCLK);
    check("in_parity", 32'({bus.tx_out, bus.tx_active_flag}), 32'h3);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_reset", 32'({bus.tx_out, bus.tx_active_flag, bus.tx_done_flag}), 32'h4);
    bus.DATA_TX = 8'h3C; bus.parity_type = 2'b01; bus.baud_rate = 2'b11;
    bus.send = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    expect_frame("post_reset", 8'h3C, 2'b01, 2'b11, 0, acnt, psmp);

    for (int unsigned r = 0; r < 8; r++) begin
      rd = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      launch(rd, rp, rb);
      expect_frame($sformatf("rand%0d", r), rd, rp, rb, 0, acnt, psmp);
    end

    bus.send = 1'b0;
    launch(8'hE1, 2'b01, 2'b11);
    waited = 0;
    @(negedge PCLK);
    while (bus.tx_active_flag === 1'b1 && waited < 400) begin
      @(negedge PCLK);
      waited++;
    end
    check("bounded_wait_done", 32'({bus.tx_active_flag, bus.tx_done_flag}), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, the PCLK frequency in Hz used to derive the baud divisors.
REQ-002 SHALL have port PCLK, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port tx_enable, input, 1 bit: transmitter enable from the APB bridge.
REQ-005 SHALL have port send, input, 1 bit: send request, a level held high by the bridge.
REQ-006 SHALL have port DATA_TX, input, 8 bits: byte to transmit.
REQ-007 SHALL have port parity_type, input, 2 bits: 00 none, 01 odd, 10 even, 11 none.
REQ-008 SHALL have port baud_rate, input, 2 bits: 00 9600, 01 19200, 10 38400, 11 115200.
REQ-009 SHALL have port tx_out, output, 1 bit: serial line; idle level is 1.
REQ-010 SHALL have port tx_active_flag, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port tx_done_flag, output, 1 bit: sticky indication that a frame completed.

Function
REQ-012 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL use bit period DIV = CLK_FREQ / baud, integer-truncated, computed at elaboration for all four codes.
REQ-014 SHALL hold each bit on tx_out for exactly DIV PCLK cycles, timed by a baud counter that is reloaded on every state entry.
REQ-015 SHALL accept a frame only in IDLE, with tx_enable=1, on a send rising edge (send=1 while registered send_d=0).
- A frame accepted at edge N SHALL drive tx_out=0 (START) from edge N+1.
REQ-016 SHALL, on acceptance, latch DATA_TX, parity_type and baud_rate; input changes mid-frame SHALL have no effect on that frame.
REQ-017 SHALL send the frame as: 1 start bit (0), 8 data bits LSB first, one parity bit only when parity is odd/even, then the stop bit(s) (1).
REQ-018 SHALL compute parity from the latched byte:
- even: parity bit = XOR of the 8 bits;
- odd: parity bit = inverted XOR.
REQ-019 SHALL track DATA bits with a 3-bit index; after bit 7 the next state SHALL be PARITY, or STOP when parity is none.
REQ-020 SHALL drive tx_active_flag=1 in every state other than IDLE.
REQ-021 SHALL, at the end of the last stop bit, return to IDLE and set tx_done_flag=1 in the same cycle.
REQ-022 SHALL clear tx_done_flag when the next frame is accepted.
REQ-023 SHALL ignore a send rising edge that occurs while not in IDLE, with no queuing.
- send still high on return to IDLE SHALL NOT start a frame.
REQ-024 SHALL abort if tx_enable=0 in any non-IDLE state:
- next edge: IDLE, tx_out=1, tx_active_flag=0;
- tx_done_flag SHALL not be set.
REQ-025 SHALL accept a frame if send rises in the same cycle tx_enable rises.
REQ-026 SHALL register tx_out, with no combinational path from inputs to tx_out.

Reset
REQ-027 SHALL, on PRESETn=0 (asynchronous, mid-frame included), force:
- state IDLE;
- tx_out=1, tx_active_flag=0, tx_done_flag=0;
- send_d=0, baud counter=0, bit index=0, latched byte=0.
REQ-028 SHALL, after PRESETn deasserts while send=1, treat send as a rising edge if tx_enable=1.

Configuration
REQ-029 SHALL, when macro UART_TX_STOP2_EN is defined, transmit two stop bits (STOP lasts 2*DIV cycles).
REQ-030 SHALL, when UART_TX_STOP2_EN is undefined, transmit one stop bit (STOP lasts DIV cycles).

Verification
REQ-031 SHALL cover: CLK_FREQ=1152000, baud 11 (DIV=10), parity 00, DATA_TX=0x55, send rises -> tx_out 0,1,0,1,0,1,0,1,0,1 each for 10 cycles; tx_done_flag=1 at cycle 101 (+10 with UART_TX_STOP2_EN).
REQ-032 SHALL cover: parity 10 with DATA_TX=0x07, then parity 01 -> parity bit 1 for even, 0 for odd; frame length 110 cycles.
REQ-033 SHALL cover: DATA_TX changed to 0xFF and baud_rate changed mid-frame -> the frame still carries the original byte at the original DIV.
REQ-034 SHALL cover: send held high across frame end, then pulsed again during the frame -> exactly one frame sent; a new frame starts only after send goes low then high.
REQ-035 SHALL cover: tx_enable dropped during DATA bit 3 -> tx_out=1 and tx_active_flag=0 next cycle, tx_done_flag stays 0.
REQ-036 SHALL cover: PRESETn pulsed low during PARITY -> all outputs at reset values immediately; a fresh send edge afterwards produces a correct frame.
